uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: OVERSAMPLE, 16, number of os_tick pulses per bit period; even, at least 8.
REQ-002 Parameter: DATA_BITS, 8, payload bits per frame.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 os_tick  input  1  one-clk strobe at OVERSAMPLE x baud rate, from the shared baud generator.
REQ-006 rx  input  1  serial line, asynchronous to clk; idle high.
REQ-007 rx_data  output  DATA_BITS  last received payload, LSB first on the line.
REQ-008 rx_valid  output  1  one-clk pulse: rx_data holds a new frame with a good stop bit.
REQ-009 frame_err  output  1  one-clk pulse: the stop bit was sampled low.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; every timing below refers to the synchronized signal rx_s.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-013 IDLE: rx_s low while os_tick is high -> START, with the tick counter cleared.
REQ-014 START: on the os_tick that brings the count to OVERSAMPLE/2, sample rx_s; low -> DATA with counters cleared; high -> IDLE (false start, no output pulse).
REQ-015 DATA: sample rx_s every OVERSAMPLE ticks (mid-bit); shift it into bit DATA_BITS-1 of the shift register, shifting right; after DATA_BITS samples -> STOP.
REQ-016 STOP: sample rx_s OVERSAMPLE ticks after the last data sample.
  - High: load rx_data from the shift register, pulse rx_valid, go to IDLE.
  - Low: pulse frame_err, leave rx_data unchanged, go to WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rx_s is high on an os_tick, then go to IDLE; break conditions therefore produce exactly one frame_err.
REQ-018 rx_valid and frame_err SHALL assert in the clk cycle after the deciding os_tick, last one cycle, and never assert together.
REQ-019 rx_data SHALL hold its value until the next rx_valid.
REQ-020 Counters and shifts SHALL advance only on os_tick, which occupies a single clk cycle.
REQ-021 The tick counter SHALL be $clog2(OVERSAMPLE) bits wide and wrap to 0 at OVERSAMPLE-1; the bit counter SHALL be $clog2(DATA_BITS+1) bits wide.
REQ-022 A start edge arriving in IDLE in the cycle right after a stop decision SHALL be accepted, so back-to-back frames are supported.
REQ-023 There is no receive FIFO; a new frame overwrites rx_data without any handshake.

Reset
REQ-024 While rst_n is low: state = IDLE, all counters and the shift register = 0, rx_data = 0, rx_valid = 0, frame_err = 0, busy = 0, synchronizer flops = 1 (idle line).
REQ-025 Asserting rst_n in the middle of a frame SHALL abort it with no output pulse; after release the block SHALL wait for a fresh falling edge.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enum and the default OVERSAMPLE and DATA_BITS constants, shared with the transmitter and the baud generator.
REQ-027 The synchronizer SHALL be a separate sub-module, sync_2ff, with a reset value parameter of 1.

Verification
REQ-028 Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 os_ticks/bit -> one rx_valid, rx_data = 0xA5, frame_err = 0.
REQ-029 rx low for 4 os_ticks, then high -> no rx_valid, no frame_err, busy returns to 0 within 8 ticks.
REQ-030 Frame 0x3C with stop bit = 0, then line held low for 40 bit periods -> exactly one frame_err, rx_data keeps its prior value, busy stays 1 until rx rises.
REQ-031 Frames 0x00, 0xFF, 0x55 back-to-back with no idle gap -> three rx_valid pulses carrying 0x00, 0xFF, 0x55 in that order.
REQ-032 rst_n pulsed low during data bit 4 of 0x81, then frame 0x7E sent -> no pulse for 0x81; rx_valid with rx_data = 0x7E.
REQ-033 Frame 0x96 with baud error of +/-3% (tick period skewed) -> rx_data = 0x96, no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART constants and receiver state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int c_OVERSAMPLE = 16;
   localparam int c_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_HIGH = 3'd4
   } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchronizer for a single asynchronous input.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Oversampling UART receiver, mid-bit sampling, stop-bit check.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = c_OVERSAMPLE,
   parameter int DATA_BITS  = c_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 os_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int c_TICK_W = $clog2(OVERSAMPLE);
   localparam int c_BIT_W  = $clog2(DATA_BITS + 1);
   localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
   localparam logic [c_TICK_W-1:0] c_TICK_HALF = c_TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);

   rx_state_e              r_state;
   logic [c_TICK_W-1:0]    r_tick_cnt;
   logic [c_BIT_W-1:0]     r_bit_cnt;
   logic [DATA_BITS-1:0]   r_shift;
   logic [DATA_BITS-1:0]   r_rx_data;
   logic                   r_rx_valid;
   logic                   r_frame_err;
   logic                   w_rx_s;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (w_rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_tick_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         if (os_tick) begin
            case (r_state)
               ST_IDLE: begin
                  if (!w_rx_s) begin
                     r_state    <= ST_START;
                     r_tick_cnt <= '0;
                  end
               end
               // Half a bit after the edge: a high line here was a glitch.
               ST_START: begin
                  if (r_tick_cnt == c_TICK_HALF) begin
                     r_tick_cnt <= '0;
                     r_bit_cnt  <= '0;
                     r_state    <= w_rx_s ? ST_IDLE : ST_DATA;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
               ST_DATA: begin
                  if (r_tick_cnt == c_TICK_LAST) begin
                     r_tick_cnt <= '0;
                     r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                     r_bit_cnt  <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt == c_BIT_LAST) begin
                        r_state <= ST_STOP;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
               ST_STOP: begin
                  if (r_tick_cnt == c_TICK_LAST) begin
                     r_tick_cnt <= '0;
                     if (w_rx_s) begin
                        r_rx_data  <= r_shift;
                        r_rx_valid <= 1'b1;
                        r_state    <= ST_IDLE;
                     end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_WAIT_HIGH;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
               // A held-low line (break) must not be re-read as new frames.
               ST_WAIT_HIGH: begin
                  if (w_rx_s) begin
                     r_state <= ST_IDLE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;
   assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx with an event-queue frame model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

   localparam int c_TICK_DIV = 4;
   localparam int c_BIT_CLKS = 16 * c_TICK_DIV;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       os_tick = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   int         n_checks = 0;
   int         n_fail = 0;
   int         n_valid = 0;
   int         n_err = 0;
   logic [7:0] model_data = 8'h00;
   ev_t        exp_q[$];

   uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .os_tick   (os_tick),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         os_tick = (cnt == c_TICK_DIV - 1);
         cnt = (cnt == c_TICK_DIV - 1) ? 0 : cnt + 1;
      end
   end

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Expected outcomes come from the frames the bench sent, in order.
   always @(negedge clk) begin
      if (!rst_n) begin
         model_data = 8'h00;
         chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
         chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
         chk("reset_busy", {31'd0, busy}, 32'd0);
         chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
      end else begin
         chk("valid_err_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
         if (rx_valid || frame_err) begin
            if (rx_valid) n_valid++;
            if (frame_err) n_err++;
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {30'd0, rx_valid, frame_err}, 32'd0);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               chk("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
               if (rx_valid && !e.is_err) begin
                  chk("frame_data", {24'd0, rx_data}, {24'd0, e.data});
                  model_data = e.data;
               end
            end
         end
         chk("rx_data_hold", {24'd0, rx_data}, {24'd0, model_data});
      end
   end

   task automatic hold(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                             input int bclk);
      ev_t e;
      e.is_err = !stop_bit;
      e.data   = d;
      exp_q.push_back(e);
      rx = 1'b0;
      hold(bclk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         hold(bclk);
      end
      rx = stop_bit;
      hold(bclk);
   endtask

   initial begin
      int v0, e0;
      logic [7:0] d81;
      hold(5);
      rst_n = 1'b1;
      hold(c_BIT_CLKS);

      // Single good frame
      v0 = n_valid; e0 = n_err;
      send_frame(8'hA5, 1'b1, c_BIT_CLKS);
      rx = 1'b1;
      hold(c_BIT_CLKS);
      chk("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
      chk("a5_valid_count", n_valid - v0, 32'd1);
      chk("a5_err_count", n_err - e0, 32'd0);

      // False start: 4 ticks low then high
      v0 = n_valid; e0 = n_err;
      rx = 1'b0;
      hold(4 * c_TICK_DIV);
      rx = 1'b1;
      hold(8 * c_TICK_DIV + 2);
      chk("false_start_busy", {31'd0, busy}, 32'd0);
      chk("false_start_valid", n_valid - v0, 32'd0);
      chk("false_start_err", n_err - e0, 32'd0);
      hold(c_BIT_CLKS);

      // Bad stop bit followed by a 40-bit break
      v0 = n_valid; e0 = n_err;
      send_frame(8'h3C, 1'b0, c_BIT_CLKS);
      hold(39 * c_BIT_CLKS);
      chk("break_busy_high", {31'd0, busy}, 32'd1);
      chk("break_err_count", n_err - e0, 32'd1);
      chk("break_valid_count", n_valid - v0, 32'd0);
      chk("break_data_kept", {24'd0, rx_data}, 32'h0000_00A5);
      rx = 1'b1;
      hold(4 * c_TICK_DIV);
      chk("break_busy_low", {31'd0, busy}, 32'd0);
      hold(c_BIT_CLKS);

      // Back-to-back frames, no idle gap
      v0 = n_valid; e0 = n_err;
      send_frame(8'h00, 1'b1, c_BIT_CLKS);
      send_frame(8'hFF, 1'b1, c_BIT_CLKS);
      send_frame(8'h55, 1'b1, c_BIT_CLKS);
      rx = 1'b1;
      hold(c_BIT_CLKS);
      chk("b2b_valid_count", n_valid - v0, 32'd3);
      chk("b2b_err_count", n_err - e0, 32'd0);
      chk("b2b_last_data", {24'd0, rx_data}, 32'h0000_0055);

      // Reset in the middle of data bit 4 of 0x81, then 0x7E
      v0 = n_valid; e0 = n_err;
      d81 = 8'h81;
      rx = 1'b0;
      hold(c_BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         rx = d81[i];
         hold(c_BIT_CLKS);
      end
      rx = d81[4];
      hold(c_BIT_CLKS / 2);
      rst_n = 1'b0;
      rx = 1'b1;
      hold(3);
      chk("abort_data_cleared", {24'd0, rx_data}, 32'd0);
      rst_n = 1'b1;
      hold(2 * c_BIT_CLKS);
      chk("abort_no_valid", n_valid - v0, 32'd0);
      chk("abort_no_err", n_err - e0, 32'd0);
      send_frame(8'h7E, 1'b1, c_BIT_CLKS);
      rx = 1'b1;
      hold(c_BIT_CLKS);
      chk("after_abort_data", {24'd0, rx_data}, 32'h0000_007E);
      chk("after_abort_valid", n_valid - v0, 32'd1);

      // Baud error of roughly +3% and -3%
      v0 = n_valid; e0 = n_err;
      send_frame(8'h96, 1'b1, 66);
      rx = 1'b1;
      hold(c_BIT_CLKS);
      chk("slow_baud_data", {24'd0, rx_data}, 32'h0000_0096);
      send_frame(8'h69, 1'b1, 62);
      rx = 1'b1;
      hold(c_BIT_CLKS);
      chk("fast_baud_data", {24'd0, rx_data}, 32'h0000_0069);
      chk("skew_valid_count", n_valid - v0, 32'd2);
      chk("skew_err_count", n_err - e0, 32'd0);

      chk("pending_events", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
